// File: rtl/nw_stream_aligner_if.sv
// Traceback coordinate stream from the aligner to the alignment writer.
// The master drives coordinates and the slave accepts them with tb_ready.
interface nw_stream_aligner_if #(
  parameter int CORD_LENGTH = 8
);
  logic                   tb_valid;
  logic                   tb_ready;
  logic [CORD_LENGTH-1:0] tb_x;
  logic [CORD_LENGTH-1:0] tb_y;
  logic                   tb_last;

  modport master (
    output tb_valid,
    output tb_x,
    output tb_y,
    output tb_last,
    input  tb_ready
  );

  modport slave (
    input  tb_valid,
    input  tb_x,
    input  tb_y,
    input  tb_last,
    output tb_ready
  );
endinterface

// File: rtl/nw_stream_aligner.sv
// Sequential Needleman-Wunsch scorer: one DP cell per clock through a row buffer,
// then the traceback path is streamed as (x,y) coordinates over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; latches strings, lengths and weights on a legal start
// FILL  | computing cell (y,x) row-major, writing H to the row buffer and dir RAM
// TRACE | presenting the current path coordinate, stepping on each handshake
module nw_stream_aligner #(
  parameter int         MAX_LEN     = 16,
  parameter int         CWIDTH      = 2,
  parameter int         SWIDTH      = 16,
  parameter int         CORD_LENGTH = 8,
  parameter logic [1:0] TOP_DIR     = 2'b00,
  parameter logic [1:0] LEFT_DIR    = 2'b01,
  parameter logic [1:0] CORNER_DIR  = 2'b10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CORD_LENGTH-1:0]        len1,
  input  logic [CORD_LENGTH-1:0]        len2,
  input  logic [MAX_LEN*CWIDTH-1:0]     s1,
  input  logic [MAX_LEN*CWIDTH-1:0]     s2,
  input  logic signed [SWIDTH-1:0]      match_w,
  input  logic signed [SWIDTH-1:0]      mismatch_w,
  input  logic signed [SWIDTH-1:0]      indel_w,
  output logic                          busy,
  output logic                          error,
  output logic signed [SWIDTH-1:0]      score,
  output logic                          score_valid,
  nw_stream_aligner_if.master           tb,
  output logic                          done
);

  localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {IDLE, FILL, TRACE} state_t;

  state_t                       state;
  logic [MAX_LEN*CWIDTH-1:0]    s1_q, s2_q;
  logic [CORD_LENGTH-1:0]       len1_q, len2_q;
  logic signed [SWIDTH-1:0]     match_q, mismatch_q, indel_q;
  logic [CORD_LENGTH-1:0]       x_q, y_q;
  logic signed [SWIDTH-1:0]     x_ind, y_ind;
  logic signed [SWIDTH-1:0]     left_q, diag_q;

  logic                         tb_valid_q, tb_last_q;
  logic [CORD_LENGTH-1:0]       tb_x_q, tb_y_q;

  logic signed [SWIDTH-1:0]     row_buf [MAX_LEN];
  logic [1:0]                   dir_mem [MAX_LEN][MAX_LEN];

  logic [IDXW-1:0]              xi, yi, txi, tyi;
  logic [CWIDTH-1:0]            c1, c2;
  logic signed [SWIDTH-1:0]     above, left, corner;
  logic signed [SWIDTH-1:0]     cand_a, cand_l, cand_c, h;
  logic [1:0]                   dir, trace_dir;
  logic                         row_end, last_cell;
  logic [CORD_LENGTH-1:0]       next_x, next_y;

  function automatic logic [CWIDTH-1:0] char_at(input logic [MAX_LEN*CWIDTH-1:0] s,
                                                input logic [IDXW-1:0] i);
    return s[(MAX_LEN - 1 - int'(i)) * CWIDTH +: CWIDTH];
  endfunction

  function automatic logic len_ok(input logic [CORD_LENGTH-1:0] l);
    return (l != '0) && (l <= CORD_LENGTH'(MAX_LEN));
  endfunction

  assign xi  = x_q[IDXW-1:0];
  assign yi  = y_q[IDXW-1:0];
  assign txi = tb_x_q[IDXW-1:0];
  assign tyi = tb_y_q[IDXW-1:0];
  assign c1  = char_at(s1_q, yi);
  assign c2  = char_at(s2_q, xi);

  // x_ind / y_ind track x*indel and y*indel so the borders need no multiplier.
  always_comb begin
    above  = (y_q == '0) ? x_ind + indel_q : row_buf[xi];
    left   = (x_q == '0) ? y_ind + indel_q : left_q;
    corner = (y_q == '0) ? x_ind : ((x_q == '0) ? y_ind : diag_q);
    cand_a = above + indel_q;
    cand_l = left + indel_q;
    cand_c = corner + ((c1 == c2) ? match_q : mismatch_q);
    if (cand_a > cand_l && cand_a > cand_c) begin
      h   = cand_a;
      dir = TOP_DIR;
    end else if (cand_l > cand_a && cand_l > cand_c) begin
      h   = cand_l;
      dir = LEFT_DIR;
    end else begin
      h   = cand_c;
      dir = CORNER_DIR;
    end
  end

  assign row_end   = (x_q == len2_q - CORD_LENGTH'(1));
  assign last_cell = row_end && (y_q == len1_q - CORD_LENGTH'(1));

  always_comb begin
    trace_dir = dir_mem[tyi][txi];
    next_x    = tb_x_q;
    next_y    = tb_y_q;
    if (tb_x_q == '0 || trace_dir == TOP_DIR) begin
      next_y = tb_y_q - CORD_LENGTH'(1);
    end else if (tb_y_q == '0 || trace_dir == LEFT_DIR) begin
      next_x = tb_x_q - CORD_LENGTH'(1);
    end else begin
      next_x = tb_x_q - CORD_LENGTH'(1);
      next_y = tb_y_q - CORD_LENGTH'(1);
    end
  end

  // Row buffer holds H[y-1][x] until cell (y,x) overwrites it with H[y][x].
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      row_buf[xi]     <= h;
      dir_mem[yi][xi] <= dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      error       <= 1'b0;
      done        <= 1'b0;
      score       <= '0;
      score_valid <= 1'b0;
      tb_valid_q  <= 1'b0;
      tb_last_q   <= 1'b0;
      tb_x_q      <= '0;
      tb_y_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      len1_q      <= '0;
      len2_q      <= '0;
      match_q     <= '0;
      mismatch_q  <= '0;
      indel_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_ind       <= '0;
      y_ind       <= '0;
      left_q      <= '0;
      diag_q      <= '0;
    end else begin
      error <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok(len1) && len_ok(len2)) begin
              s1_q        <= s1;
              s2_q        <= s2;
              len1_q      <= len1;
              len2_q      <= len2;
              match_q     <= match_w;
              mismatch_q  <= mismatch_w;
              indel_q     <= indel_w;
              x_q         <= '0;
              y_q         <= '0;
              x_ind       <= '0;
              y_ind       <= '0;
              busy        <= 1'b1;
              score_valid <= 1'b0;
              state       <= FILL;
            end else begin
              error <= 1'b1;
            end
          end
        end
        FILL: begin
          left_q <= h;
          diag_q <= above;
          if (row_end) begin
            x_q   <= '0;
            x_ind <= '0;
            y_q   <= y_q + CORD_LENGTH'(1);
            y_ind <= y_ind + indel_q;
          end else begin
            x_q   <= x_q + CORD_LENGTH'(1);
            x_ind <= x_ind + indel_q;
          end
          if (last_cell) begin
            score       <= h;
            score_valid <= 1'b1;
            tb_valid_q  <= 1'b1;
            tb_x_q      <= len2_q - CORD_LENGTH'(1);
            tb_y_q      <= len1_q - CORD_LENGTH'(1);
            tb_last_q   <= (len1_q == CORD_LENGTH'(1)) && (len2_q == CORD_LENGTH'(1));
            state       <= TRACE;
          end
        end
        TRACE: begin
          if (tb_valid_q && tb.tb_ready) begin
            if (tb_last_q) begin
              tb_valid_q <= 1'b0;
              tb_last_q  <= 1'b0;
              tb_x_q     <= '0;
              tb_y_q     <= '0;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              tb_x_q    <= next_x;
              tb_y_q    <= next_y;
              tb_last_q <= (next_x == '0) && (next_y == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tb.tb_valid = tb_valid_q;
  assign tb.tb_x     = tb_x_q;
  assign tb.tb_y     = tb_y_q;
  assign tb.tb_last  = tb_last_q;

endmodule

// File: tb/tb_nw_stream_aligner.sv
// Directed bench for nw_stream_aligner with MAX_LEN=4 and hand-computed
// scores and traceback paths.
module tb_nw_stream_aligner;
  localparam int MAX_LEN = 4;
  localparam int CWIDTH  = 2;
  localparam int SWIDTH  = 16;
  localparam int CL      = 8;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [CL-1:0]               len1, len2;
  logic [MAX_LEN*CWIDTH-1:0]   s1, s2;
  logic signed [SWIDTH-1:0]    match_w, mismatch_w, indel_w;
  logic                        busy, error, score_valid, done;
  logic signed [SWIDTH-1:0]    score;

  nw_stream_aligner_if #(.CORD_LENGTH(CL)) tb_if ();

  nw_stream_aligner #(
    .MAX_LEN(MAX_LEN), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .CORD_LENGTH(CL)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .len1(len1), .len2(len2), .s1(s1), .s2(s2),
    .match_w(match_w), .mismatch_w(mismatch_w), .indel_w(indel_w),
    .busy(busy), .error(error), .score(score), .score_valid(score_valid),
    .tb(tb_if), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_align(input logic [7:0] a, input logic [7:0] b,
                           input int l1, input int l2,
                           input int m, input int mm, input int ind,
                           input int exp_score, input int n,
                           input int xs[4], input int ys[4], input int stall_beat);
    int cnt;
    s1 = a; s2 = b;
    len1 = l1[CL-1:0]; len2 = l2[CL-1:0];
    match_w = m[SWIDTH-1:0]; mismatch_w = mm[SWIDTH-1:0]; indel_w = ind[SWIDTH-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("score_valid_cleared", int'(score_valid), 0);
    cnt = 0;
    while (!tb_if.tb_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    check("fill_cycles", cnt, l1 * l2);
    check("score", int'(score), exp_score);
    check("score_valid", int'(score_valid), 1);
    tb_if.tb_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("tb_valid", int'(tb_if.tb_valid), 1);
      check("tb_x", int'(tb_if.tb_x), xs[i]);
      check("tb_y", int'(tb_if.tb_y), ys[i]);
      check("tb_last", int'(tb_if.tb_last), (i == n - 1) ? 1 : 0);
      if (i == stall_beat) begin
        tb_if.tb_ready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_valid", int'(tb_if.tb_valid), 1);
          check("stall_x", int'(tb_if.tb_x), xs[i]);
          check("stall_y", int'(tb_if.tb_y), ys[i]);
        end
        tb_if.tb_ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", int'(done), 1);
    check("busy_fall", int'(busy), 0);
    check("tb_valid_fall", int'(tb_if.tb_valid), 0);
    tb_if.tb_ready = 1'b0;
    tick();
    check("done_cleared", int'(done), 0);
    check("score_hold", int'(score), exp_score);
    check("score_valid_hold", int'(score_valid), 1);
  endtask

  task automatic check_reset_values();
    check("rst_busy", int'(busy), 0);
    check("rst_error", int'(error), 0);
    check("rst_score", int'(score), 0);
    check("rst_score_valid", int'(score_valid), 0);
    check("rst_tb_valid", int'(tb_if.tb_valid), 0);
    check("rst_tb_x", int'(tb_if.tb_x), 0);
    check("rst_tb_y", int'(tb_if.tb_y), 0);
    check("rst_tb_last", int'(tb_if.tb_last), 0);
    check("rst_done", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; tb_if.tb_ready = 1'b0;
    len1 = '0; len2 = '0; s1 = '0; s2 = '0;
    match_w = '0; mismatch_w = '0; indel_w = '0;
    repeat (2) tick();
    check_reset_values();
    reset = 1'b0;
    tick();

    // ACGT vs ACGT, 1/-1/-1
    run_align(8'b00011011, 8'b00011011, 4, 4, 1, -1, -1, 4, 4,
              '{3, 2, 1, 0}, '{3, 2, 1, 0}, -1);
    // AAAA vs TTTT
    run_align(8'b00000000, 8'b11111111, 4, 4, 1, -1, -1, -4, 4,
              '{3, 2, 1, 0}, '{3, 2, 1, 0}, -1);
    // AC vs ACGT
    run_align(8'b00010000, 8'b00011011, 2, 4, 1, -1, -1, 0, 4,
              '{3, 2, 1, 0}, '{1, 1, 1, 0}, -1);
    // ACGT vs ACGT, 2/-1/-2, consumer stalls on the second beat
    run_align(8'b00011011, 8'b00011011, 4, 4, 2, -1, -2, 8, 4,
              '{3, 2, 1, 0}, '{3, 2, 1, 0}, 1);

    // illegal lengths
    len1 = 8'd0; len2 = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_len1_zero", int'(error), 1);
    check("err_len1_busy", int'(busy), 0);
    check("err_len1_sv", int'(score_valid), 1);
    tick();
    check("err_len1_pulse_end", int'(error), 0);
    len1 = 8'd4; len2 = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_len2_big", int'(error), 1);
    check("err_len2_busy", int'(busy), 0);
    check("err_len2_sv", int'(score_valid), 1);
    tick();
    check("err_len2_pulse_end", int'(error), 0);
    check("err_score_hold", int'(score), 8);

    // reset mid-FILL, with an ignored start while busy
    s1 = 8'b00011011; s2 = 8'b00011011; len1 = 8'd4; len2 = 8'd4;
    match_w = 16'sd1; mismatch_w = -16'sd1; indel_w = -16'sd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    len1 = 8'd0; start = 1'b1;
    tick();
    start = 1'b0; len1 = 8'd4;
    check("busy_start_no_error", int'(error), 0);
    check("busy_start_still_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    tick();
    run_align(8'b00011011, 8'b00011011, 4, 4, 1, -1, -1, 4, 4,
              '{3, 2, 1, 0}, '{3, 2, 1, 0}, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
